// File: rtl/vga_draw_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter_pkg
// Shared definitions for the VGA pixel-port arbiter and its clients:
//   - requester index constants (index 0 has the highest priority)
//   - arbiter state encoding
//   - default coordinate / colour widths of the 320x240 VGA adapter
// -----------------------------------------------------------------------------
package vga_draw_arbiter_pkg;

  // Requester slots on the arbiter; lower index wins when several ask at once.
  localparam int REQ_SCREEN  = 0;
  localparam int REQ_MAZE    = 1;
  localparam int REQ_SPECIAL = 2;
  localparam int REQ_DRAW    = 3;
  localparam int REQ_ERASE   = 4;
  localparam int NUM_ENGINES = 5;

  // Default pixel-port widths.
  localparam int DEF_XW = 9;
  localparam int DEF_YW = 9;
  localparam int DEF_CW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Saturating increment for counters that must never wrap.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/vga_draw_arbiter_priority_encoder_onehot.sv
// -----------------------------------------------------------------------------
// priority_encoder_onehot
// Fixed-priority encoder: the lowest set bit of req wins.
// Ports:
//   req    in  N   request vector
//   onehot out N   one-hot of the winning index (all zero when no request)
//   idx    out IW  binary winning index (0 when no request)
//   valid  out 1   at least one request bit set
// Purely combinational; also usable by the game FSM for its own job selection.
// -----------------------------------------------------------------------------
module priority_encoder_onehot #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the lowest set index is the last to overwrite.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter
// Registered, handshaked arbiter that shares the single VGA pixel-write port
// among the drawing engines. A grant is held for a whole drawing job and only
// the granted engine's coordinates/colour reach the adapter.
//
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   req  [NUM_REQ]    per-engine job request (level, held for the job)
//   done [NUM_REQ]    per-engine one-cycle job-complete pulse
//   x_in/y_in/colour_in  packed per-engine pixel data, engine i at [i*W +: W]
//   grant [NUM_REQ]   one-hot grant, zero when idle
//   x/y/colour/plot   registered pixel write to vga_adapter
//   busy              arbiter not idle
//   timeout_err       sticky: some grant was force-released
//   pix_count         pixels plotted in the current / most recent grant
//
// Timing: pixel data is registered, so outputs lag the engine by one cycle.
// plot is the registered "previous cycle was GRANT" flag: it is low in the
// first GRANT cycle (nothing captured yet) and high in the RELEASE cycle,
// which carries the pixel presented during the completing cycle.
// -----------------------------------------------------------------------------
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 5,
  parameter int XW          = DEF_XW,
  parameter int YW          = DEF_YW,
  parameter int CW          = DEF_CW,
  parameter int TIMEOUT_CYC = 131072,
  parameter int CNT_W       = 17
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    done,
  input  logic [NUM_REQ*XW-1:0] x_in,
  input  logic [NUM_REQ*YW-1:0] y_in,
  input  logic [NUM_REQ*CW-1:0] colour_in,
  output logic [NUM_REQ-1:0]    grant,
  output logic [XW-1:0]         x,
  output logic [YW-1:0]         y,
  output logic [CW-1:0]         colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      pix_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  // Per-engine views of the packed input buses.
  logic [NUM_REQ-1:0][XW-1:0] x_arr;
  logic [NUM_REQ-1:0][YW-1:0] y_arr;
  logic [NUM_REQ-1:0][CW-1:0] c_arr;
  assign x_arr = x_in;
  assign y_arr = y_in;
  assign c_arr = colour_in;

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [CW-1:0]       colour_q, colour_d;
  logic                plot_q, plot_d;
  logic [CNT_W-1:0]    pix_q, pix_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                terr_q, terr_d;

  // Winner among the current requests; only consulted in IDLE.
  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_vld;

  priority_encoder_onehot #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_penc (
    .req    (req),
    .onehot (win_oh),
    .idx    (win_idx),
    .valid  (win_vld)
  );

  // Release checks use the one-hot grant so done/req on other engines are
  // masked off; done together with a dropped req is still one release.
  logic own_done, own_req, tmo_hit, rel;
  assign own_done = |(done & grant_q);
  assign own_req  = |(req & grant_q);
  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign rel      = own_done | ~own_req | tmo_hit;

  // State register plus all datapath flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      pix_q    <= '0;
      tmo_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      pix_q    <= pix_d;
      tmo_q    <= tmo_d;
      terr_q   <= terr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_vld) state_d = GRANT;
      GRANT:   if (rel)     state_d = RELEASE;
      RELEASE:              state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    tmo_d    = tmo_q;
    pix_d    = pix_q;
    terr_d   = terr_q;
    // Any GRANT cycle captures a pixel, so the next cycle plots it.
    plot_d   = (state_q == GRANT);
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win_oh;
          gidx_d  = win_idx;
          tmo_d   = '0;
          pix_d   = '0;
        end
      end
      GRANT: begin
        x_d      = x_arr[gidx_q];
        y_d      = y_arr[gidx_q];
        colour_d = c_arr[gidx_q];
        // Counted on the edge where plot rises, so pix_count tracks plot.
        if (pix_q != '1) pix_d = pix_q + 1'b1;
        if (rel) begin
          grant_d = '0;
          if (tmo_hit) terr_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign grant       = grant_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;
  assign pix_count   = pix_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_draw_arbiter
// Table-driven check of the pixel-port arbiter: each record drives one cycle of
// inputs and lists the outputs expected just after the following clock edge.
// Hand-written sequences cover reset, timeout and reset in the middle of a job.
// The granted-looking slice gets the record's pixel data; every other slice gets
// its bitwise inverse, so a wrong mux selection shows up as a data error.
// -----------------------------------------------------------------------------
module tb_vga_draw_arbiter;
  import vga_draw_arbiter_pkg::*;

  localparam int N   = 5;
  localparam int XW  = 9;
  localparam int YW  = 9;
  localparam int CW  = 3;
  localparam int TMO = 16;
  localparam int CNW = 17;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   done = '0;
  logic [N*XW-1:0] x_in = '0;
  logic [N*YW-1:0] y_in = '0;
  logic [N*CW-1:0] colour_in = '0;
  logic [N-1:0]   grant;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [CW-1:0]  colour;
  logic           plot, busy, timeout_err;
  logic [CNW-1:0] pix_count;

  vga_draw_arbiter #(
    .NUM_REQ(N), .XW(XW), .YW(YW), .CW(CW), .TIMEOUT_CYC(TMO), .CNT_W(CNW)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .timeout_err(timeout_err), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] done;
    int           sel;
    int           xv, yv, cv;
    logic [N-1:0] e_grant;
    logic         e_plot;
    int           e_x, e_y, e_c;
    logic         e_busy;
    int           e_pix;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [N-1:0] r, logic [N-1:0] d, int s,
                              int xv, int yv, int cv,
                              logic [N-1:0] g, logic p, int ex, int ey, int ec,
                              logic b, int pix);
    vec_t v;
    v.req = r; v.done = d; v.sel = s; v.xv = xv; v.yv = yv; v.cv = cv;
    v.e_grant = g; v.e_plot = p; v.e_x = ex; v.e_y = ey; v.e_c = ec;
    v.e_busy = b; v.e_pix = pix;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d, input int s,
                       input int xv, input int yv, input int cv);
    req  = r;
    done = d;
    for (int i = 0; i < N; i++) begin
      x_in[i*XW +: XW]      = (i == s) ? XW'(xv) : ~XW'(xv);
      y_in[i*YW +: YW]      = (i == s) ? YW'(yv) : ~YW'(yv);
      colour_in[i*CW +: CW] = (i == s) ? CW'(cv) : ~CW'(cv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hold;
    int guard;

    // ---------------- job table ----------------
    // single job on engine 1: x 0..9, y 7, colour 6, done with x=9
    vt.push_back(mk(5'b00010, 5'b00000, 1, 0, 7, 6, 5'b00010, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 9; k++)
      vt.push_back(mk(5'b00010, 5'b00000, 1, k, 7, 6, 5'b00010, 1, k, 7, 6, 1, k + 1));
    vt.push_back(mk(5'b00010, 5'b00010, 1, 9, 7, 6, 5'b00000, 1, 9, 7, 6, 1, 10));
    vt.push_back(mk(5'b00000, 5'b00000, 1, 9, 7, 6, 5'b00000, 0, 0, 0, 0, 0, 10));
    // engine 3 granted, engine 0 arrives: no preemption; stray done[0] ignored
    vt.push_back(mk(5'b01000, 5'b00000, 3, 20, 30, 5, 5'b01000, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(5'b01001, 5'b00001, 3, 21, 30, 5, 5'b01000, 1, 21, 30, 5, 1, 1));
    vt.push_back(mk(5'b01001, 5'b01000, 3, 22, 30, 5, 5'b00000, 1, 22, 30, 5, 1, 2));
    vt.push_back(mk(5'b00001, 5'b00000, 0, 50, 60, 1, 5'b00000, 0, 0, 0, 0, 0, 2));
    vt.push_back(mk(5'b00001, 5'b00000, 0, 50, 60, 1, 5'b00001, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(5'b00001, 5'b00001, 0, 50, 60, 1, 5'b00000, 1, 50, 60, 1, 1, 1));
    vt.push_back(mk(5'b00000, 5'b00000, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 1));
    // simultaneous 10110: grants 1, 2, 4 with one idle cycle between
    vt.push_back(mk(5'b10110, 5'b00000, 1, 1, 2, 3, 5'b00010, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(5'b10110, 5'b00010, 1, 5, 6, 7, 5'b00000, 1, 5, 6, 7, 1, 1));
    vt.push_back(mk(5'b10100, 5'b00000, 2, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b10100, 5'b00000, 2, 0, 0, 0, 5'b00100, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(5'b10100, 5'b00100, 2, 100, 101, 2, 5'b00000, 1, 100, 101, 2, 1, 1));
    vt.push_back(mk(5'b10000, 5'b00000, 4, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'b10000, 5'b00000, 4, 0, 0, 0, 5'b10000, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(5'b10000, 5'b00000, 4, 300, 400, 4, 5'b10000, 1, 300, 400, 4, 1, 1));
    // engine 4 abandons (req drops, no done): release, last pixel still plotted
    vt.push_back(mk(5'b00000, 5'b00000, 4, 301, 401, 4, 5'b00000, 1, 301, 401, 4, 1, 2));
    vt.push_back(mk(5'b00000, 5'b00000, 4, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 2));

    // ---------------- reset with all requests pending ----------------
    resetn = 1'b0;
    drive(5'b11111, 5'b00000, 0, 3, 4, 5);
    repeat (3) step();
    chk("rst_grant", grant, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_pix", pix_count, 0);
    chk("rst_x", x, 0);
    resetn = 1'b1;
    step();
    chk("post_rst_grant", grant, 5'b00001);
    drive(5'b00000, 5'b00000, 0, 3, 4, 5);
    step();
    step();
    chk("post_rst_idle", busy, 0);

    // ---------------- table ----------------
    foreach (vt[i]) begin
      drive(vt[i].req, vt[i].done, vt[i].sel, vt[i].xv, vt[i].yv, vt[i].cv);
      step();
      chk($sformatf("v%0d_grant", i), grant, vt[i].e_grant);
      chk($sformatf("v%0d_plot", i), plot, vt[i].e_plot);
      chk($sformatf("v%0d_x", i), x, vt[i].e_x);
      chk($sformatf("v%0d_y", i), y, vt[i].e_y);
      chk($sformatf("v%0d_c", i), colour, vt[i].e_c);
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d_pix", i), pix_count, vt[i].e_pix);
      chk($sformatf("v%0d_terr", i), timeout_err, 0);
    end

    // ---------------- timeout on engine 2 ----------------
    drive(5'b00100, 5'b00000, REQ_SPECIAL, 33, 44, 5);
    step();
    chk("tmo_first_grant", grant, 5'b00100);
    hold = 1;
    guard = 0;
    while (grant == 5'b00100 && guard < 40) begin
      step();
      guard++;
      if (grant == 5'b00100) hold++;
    end
    chk("tmo_hold_cycles", hold, TMO);
    chk("tmo_grant_cleared", grant, 0);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_last_plot", plot, 1);
    chk("tmo_pix", pix_count, TMO);
    chk("tmo_last_x", x, 33);
    drive(5'b00000, 5'b00000, 0, 0, 0, 0);
    step();
    chk("tmo_idle", busy, 0);

    // normal job afterwards: error flag stays sticky
    drive(5'b00001, 5'b00000, REQ_SCREEN, 7, 8, 2);
    step();
    chk("sticky_grant", grant, 5'b00001);
    drive(5'b00001, 5'b00001, REQ_SCREEN, 7, 8, 2);
    step();
    drive(5'b00000, 5'b00000, 0, 0, 0, 0);
    step();
    chk("sticky_busy", busy, 0);
    chk("sticky_terr", timeout_err, 1);

    // ---------------- reset in the middle of a grant ----------------
    drive(5'b01000, 5'b00000, REQ_DRAW, 99, 88, 7);
    step();
    step();
    chk("mid_pre_plot", plot, 1);
    resetn = 1'b0;
    step();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_pix", pix_count, 0);
    resetn = 1'b1;
    drive(5'b00000, 5'b00000, 0, 0, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
